// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared defaults and types for the scoreboarded register file
package reg_file_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int AW_DEF   = $clog2(NREG_DEF);

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] reg_data_t;

endpackage

// File: rtl/reg_file_rport.sv
// rtl/reg_file_rport.sv - one combinational read port: zero register, write bypass, busy masking
module reg_file_rport
    import reg_file_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int AW       = AW_DEF,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic [AW-1:0]   ra,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd,
    input  logic [XLEN-1:0] rf_word,
    input  logic            busy_bit,
    output logic [XLEN-1:0] rd,
    output logic            rbusy
);

    logic is_zero;
    logic bypass;

    assign is_zero = ZERO_REG && (ra == '0);
    assign bypass  = we && (wa == ra);

    always_comb begin
        rd = rf_word;
        if (is_zero)
            rd = '0;
        else if (bypass)
            rd = wd;
    end

    // A writeback landing this cycle satisfies the pending reservation.
    assign rbusy = busy_bit && !bypass && !is_zero;

endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - multi-read-port register file with per-register busy scoreboard
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREG     = NREG_DEF,
    parameter int NRD      = 2,
    parameter bit ZERO_REG = 1'b1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NRD-1:0][AW-1:0]   RA,
    output logic [NRD-1:0][XLEN-1:0] RD,
    output logic [NRD-1:0]           RBUSY,
    input  logic                     WE,
    input  logic [AW-1:0]            WA,
    input  logic [XLEN-1:0]          WD,
    input  logic                     ISS,
    input  logic [AW-1:0]            IA,
    output logic [AW:0]              PEND
);

    logic [XLEN-1:0] rf [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [AW:0]     pend_q;

    logic we_eff;
    logic iss_eff;
    logic pend_inc;
    logic pend_dec;

    assign we_eff  = WE  && !(ZERO_REG && (WA == '0));
    assign iss_eff = ISS && !(ZERO_REG && (IA == '0));

    // Issue is applied after writeback so a same-address pair leaves the bit set.
    always_comb begin
        busy_d = busy_q;
        if (we_eff)
            busy_d[WA] = 1'b0;
        if (iss_eff)
            busy_d[IA] = 1'b1;
    end

    assign pend_inc = iss_eff && !busy_q[IA];
    assign pend_dec = we_eff && busy_q[WA] && !(iss_eff && (IA == WA));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NREG; i++)
                rf[i] <= '0;
            busy_q <= '0;
            pend_q <= '0;
        end else begin
            if (we_eff)
                rf[WA] <= WD;
            busy_q <= busy_d;
            pend_q <= pend_q + {{AW{1'b0}}, pend_inc} - {{AW{1'b0}}, pend_dec};
        end
    end

    assign PEND = pend_q;

    for (genvar i = 0; i < NRD; i++) begin : g_rport
        reg_file_rport #(
            .XLEN     (XLEN),
            .AW       (AW),
            .ZERO_REG (ZERO_REG)
        ) u_rport (
            .ra       (RA[i]),
            .we       (WE),
            .wa       (WA),
            .wd       (WD),
            .rf_word  (rf[RA[i]]),
            .busy_bit (busy_q[RA[i]]),
            .rd       (RD[i]),
            .rbusy    (RBUSY[i])
        );
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - scoreboard bench for reg_file_sb with directed vectors
module tb_reg_file_sb;
    import reg_file_pkg::*;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    localparam int K_RD    = 0;
    localparam int K_RBUSY = 1;
    localparam int K_PEND  = 2;

    logic                     CLK;
    logic                     RST;
    logic [NRD-1:0][AW-1:0]   RA;
    logic [NRD-1:0][XLEN-1:0] RD;
    logic [NRD-1:0]           RBUSY;
    logic                     WE;
    logic [AW-1:0]            WA;
    logic [XLEN-1:0]          WD;
    logic                     ISS;
    logic [AW-1:0]            IA;
    logic [AW:0]              PEND;

    reg_file_sb #(
        .XLEN     (XLEN),
        .NREG     (NREG),
        .NRD      (NRD),
        .ZERO_REG (1'b1)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .RA    (RA),
        .RD    (RD),
        .RBUSY (RBUSY),
        .WE    (WE),
        .WA    (WA),
        .WD    (WD),
        .ISS   (ISS),
        .IA    (IA),
        .PEND  (PEND)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        int          kind;
        int          idx;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic expect_val(input string name, input int kind, input int idx, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.idx  = idx;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Outputs are combinational or edge-updated, so they are stable by the falling edge.
    always @(negedge CLK) begin
        while (exp_q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = exp_q.pop_front();
            case (e.kind)
                K_RD:    act = RD[e.idx];
                K_RBUSY: act = {31'd0, RBUSY[e.idx]};
                default: act = {26'd0, PEND};
            endcase
            n_total++;
            if (act === e.val)
                n_pass++;
            else
                $display("FAIL %s: got %h expected %h", e.name, act, e.val);
        end
    end

    initial begin
        reg_addr_t a;
        RST = 1'b1;
        WE  = 1'b1;
        WA  = 5'd5;
        WD  = 32'hDEADBEEF;
        ISS = 1'b0;
        IA  = '0;
        RA  = '0;
        repeat (3) cyc();

        RST = 1'b0; WE = 1'b0; RA[0] = 5'd5; RA[1] = 5'd1;
        expect_val("reset_rd", K_RD, 0, 32'h0);
        expect_val("reset_pend", K_PEND, 0, 32'd0);
        expect_val("reset_rbusy0", K_RBUSY, 0, 32'd0);
        expect_val("reset_rbusy1", K_RBUSY, 1, 32'd0);

        cyc(); WE = 1'b1; WA = 5'd3; WD = 32'h12345678; RA[0] = 5'd3;
        expect_val("bypass_same_cycle", K_RD, 0, 32'h12345678);
        cyc(); WE = 1'b0;
        expect_val("bypass_stored", K_RD, 0, 32'h12345678);
        expect_val("nonbusy_write_pend", K_PEND, 0, 32'd0);

        cyc(); ISS = 1'b1; IA = 5'd7; RA[1] = 5'd7;
        expect_val("issue_not_yet_busy", K_RBUSY, 1, 32'd0);
        cyc(); ISS = 1'b0;
        expect_val("issue_rbusy", K_RBUSY, 1, 32'd1);
        expect_val("issue_pend", K_PEND, 0, 32'd1);
        cyc(); WE = 1'b1; WA = 5'd7; WD = 32'hA5;
        expect_val("wb_rbusy_masked", K_RBUSY, 1, 32'd0);
        expect_val("wb_rd_bypass", K_RD, 1, 32'hA5);
        expect_val("wb_pend_before_edge", K_PEND, 0, 32'd1);
        cyc(); WE = 1'b0;
        expect_val("wb_pend_after", K_PEND, 0, 32'd0);
        expect_val("wb_rd_stored", K_RD, 1, 32'hA5);

        cyc(); ISS = 1'b1; IA = 5'd9;
        cyc(); WE = 1'b1; WA = 5'd9; WD = 32'hCAFE0009; RA[0] = 5'd9;
        expect_val("same_addr_pend_pre", K_PEND, 0, 32'd1);
        expect_val("same_addr_rbusy_masked", K_RBUSY, 0, 32'd0);
        cyc(); WE = 1'b0; ISS = 1'b0;
        expect_val("same_addr_pend", K_PEND, 0, 32'd1);
        expect_val("same_addr_busy", K_RBUSY, 0, 32'd1);
        expect_val("same_addr_data", K_RD, 0, 32'hCAFE0009);

        cyc(); WE = 1'b1; WA = 5'd9; WD = 32'h99; ISS = 1'b1; IA = 5'd10; RA[1] = 5'd10;
        cyc(); WE = 1'b0; ISS = 1'b0;
        expect_val("diff_addr_pend", K_PEND, 0, 32'd1);
        expect_val("diff_addr_clear", K_RBUSY, 0, 32'd0);
        expect_val("diff_addr_set", K_RBUSY, 1, 32'd1);
        expect_val("diff_addr_data", K_RD, 0, 32'h99);
        cyc(); WE = 1'b1; WA = 5'd10; WD = 32'h10;
        cyc(); WE = 1'b0;
        expect_val("clear10_pend", K_PEND, 0, 32'd0);

        cyc(); WE = 1'b1; WA = 5'd0; WD = 32'hFFFFFFFF; RA[0] = 5'd0;
        expect_val("zero_bypass_blocked", K_RD, 0, 32'h0);
        cyc(); WE = 1'b0; ISS = 1'b1; IA = 5'd0;
        expect_val("zero_not_written", K_RD, 0, 32'h0);
        cyc(); ISS = 1'b0;
        expect_val("zero_rbusy", K_RBUSY, 0, 32'd0);
        expect_val("zero_pend", K_PEND, 0, 32'd0);

        for (int r = 1; r < 32; r++) begin
            cyc(); ISS = 1'b1; a = reg_addr_t'(r); IA = a;
            expect_val("fill_pend_progress", K_PEND, 0, 32'(r - 1));
        end
        cyc(); ISS = 1'b0; RA[0] = 5'd31;
        expect_val("fill_pend_full", K_PEND, 0, 32'd31);
        expect_val("fill_rbusy31", K_RBUSY, 0, 32'd1);
        cyc(); ISS = 1'b1; IA = 5'd5;
        cyc(); ISS = 1'b0;
        expect_val("waw_pend", K_PEND, 0, 32'd31);

        cyc(); RST = 1'b1; RA[1] = 5'd3;
        expect_val("async_reset_pend", K_PEND, 0, 32'd0);
        expect_val("async_reset_rbusy", K_RBUSY, 0, 32'd0);
        expect_val("async_reset_rf", K_RD, 1, 32'h0);
        cyc(); RST = 1'b0;

        for (int r = 1; r <= 10; r++) begin
            cyc(); ISS = 1'b1; a = reg_addr_t'(r); IA = a;
        end
        cyc(); IA = 5'd11; RST = 1'b1;
        expect_val("midfill_reset_pend", K_PEND, 0, 32'd0);
        cyc(); RST = 1'b0; IA = 5'd4; RA[0] = 5'd4;
        cyc(); ISS = 1'b0;
        expect_val("post_reset_issue_pend", K_PEND, 0, 32'd1);
        expect_val("post_reset_issue_busy", K_RBUSY, 0, 32'd1);

        repeat (2) cyc();
        n_total++;
        if (exp_q.size() == 0)
            n_pass++;
        else
            $display("FAIL queue_drain: got %0d expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
